// File: rtl/fetch_queue_pkg.sv
// Shared widths and small helpers for the dual-issue fetch queue.
package fetch_queue_pkg;

  localparam int FQ_IWIDTH   = 32;
  localparam int FQ_PC_WIDTH = 32;
  localparam int FQ_DEPTH    = 3;

  // Requested pop amount; 3 is treated as a request for 2.
  function automatic logic [1:0] pop_request(input logic [1:0] cnt);
    logic [1:0] req;
    case (cnt)
      2'd0:    req = 2'd0;
      2'd1:    req = 2'd1;
      2'd2:    req = 2'd2;
      default: req = 2'd2;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode-facing bundle of the fetch queue; master drives requests, slave is the queue.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int IWIDTH   = FQ_IWIDTH,
  parameter int PC_WIDTH = FQ_PC_WIDTH,
  parameter int DEPTH    = FQ_DEPTH
);
  logic [1:0]          fq_i_push_cnt;
  logic [IWIDTH-1:0]   fq_i_instr_1;
  logic [IWIDTH-1:0]   fq_i_instr_2;
  logic [PC_WIDTH-1:0] fq_i_pc_1;
  logic [PC_WIDTH-1:0] fq_i_pc_2;
  logic [1:0]          fq_i_pop_cnt;
  logic                fq_i_flush;
  logic                fq_o_ready;
  logic [DEPTH:0]      fq_o_count;
  logic                fq_o_valid_1;
  logic                fq_o_valid_2;
  logic [IWIDTH-1:0]   fq_o_instr_1;
  logic [IWIDTH-1:0]   fq_o_instr_2;
  logic [PC_WIDTH-1:0] fq_o_pc_1;
  logic [PC_WIDTH-1:0] fq_o_pc_2;
  logic                fq_o_err;

  modport master (
    output fq_i_push_cnt, fq_i_instr_1, fq_i_instr_2, fq_i_pc_1, fq_i_pc_2,
    output fq_i_pop_cnt, fq_i_flush,
    input  fq_o_ready, fq_o_count, fq_o_valid_1, fq_o_valid_2,
    input  fq_o_instr_1, fq_o_instr_2, fq_o_pc_1, fq_o_pc_2, fq_o_err
  );

  modport slave (
    input  fq_i_push_cnt, fq_i_instr_1, fq_i_instr_2, fq_i_pc_1, fq_i_pc_2,
    input  fq_i_pop_cnt, fq_i_flush,
    output fq_o_ready, fq_o_count, fq_o_valid_1, fq_o_valid_2,
    output fq_o_instr_1, fq_o_instr_2, fq_o_pc_1, fq_o_pc_2, fq_o_err
  );
endinterface

// File: rtl/fetch_queue_mem_2w1r.sv
// Entry storage: two write ports (port 2 only alongside port 1) and two combinational reads.
module fq_mem_2w1r
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = FQ_IWIDTH + FQ_PC_WIDTH,
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic             clk,
  input  logic             we_1,
  input  logic [DEPTH-1:0] waddr_1,
  input  logic [WIDTH-1:0] wdata_1,
  input  logic             we_2,
  input  logic [DEPTH-1:0] waddr_2,
  input  logic [WIDTH-1:0] wdata_2,
  input  logic [DEPTH-1:0] raddr_1,
  output logic [WIDTH-1:0] rdata_1,
  input  logic [DEPTH-1:0] raddr_2,
  output logic [WIDTH-1:0] rdata_2
);
  logic [WIDTH-1:0] mem_r [2**DEPTH];

  // Entries are never reset; the queue masks stale contents with its valid flags.
  always_ff @(posedge clk) begin
    if (we_1) begin
      mem_r[waddr_1] <= wdata_1;
    end
    if (we_1 && we_2) begin
      mem_r[waddr_2] <= wdata_2;
    end
  end

  assign rdata_1 = mem_r[raddr_1];
  assign rdata_2 = mem_r[raddr_2];
endmodule

// File: rtl/fetch_queue.sv
// Eight-entry dual-issue instruction queue: pointers, occupancy, push/pop acceptance and slot gating.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int IWIDTH   = FQ_IWIDTH,
  parameter int PC_WIDTH = FQ_PC_WIDTH,
  parameter int DEPTH    = FQ_DEPTH
) (
  input  logic          fq_clk,
  input  logic          fq_rst,
  fetch_queue_if.slave  bus
);
  localparam int             W         = IWIDTH + PC_WIDTH;
  localparam logic [DEPTH:0] ENTRIES   = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] ONE       = {{DEPTH{1'b0}}, 1'b1};
  localparam logic [DEPTH:0] READY_MAX = ENTRIES - {{(DEPTH-1){1'b0}}, 2'd2};

  logic [DEPTH-1:0] rp_r;
  logic [DEPTH-1:0] wp_r;
  logic [DEPTH:0]   count_r;
  logic             err_r;

  logic [DEPTH:0]   pop_want_s;
  logic [DEPTH:0]   eff_pop_s;
  logic             pop_err_s;
  logic [DEPTH:0]   push_want_s;
  logic [DEPTH:0]   free_s;
  logic             push_ok_s;
  logic             push_err_s;
  logic [DEPTH:0]   push_acc_s;
  logic             we_1_s;
  logic             we_2_s;
  logic [W-1:0]     rdata_1_s;
  logic [W-1:0]     rdata_2_s;

  // Pop clamping and push acceptance, both judged against pre-edge occupancy.
  always_comb begin
    pop_want_s  = {{(DEPTH-1){1'b0}}, pop_request(bus.fq_i_pop_cnt)};
    push_want_s = {{(DEPTH-1){1'b0}}, bus.fq_i_push_cnt};
    free_s      = ENTRIES - count_r;
    if (pop_want_s > count_r) begin
      eff_pop_s = count_r;
      pop_err_s = 1'b1;
    end else begin
      eff_pop_s = pop_want_s;
      pop_err_s = (bus.fq_i_pop_cnt == 2'd3);
    end
    if ((bus.fq_i_push_cnt == 2'd3) || (push_want_s > free_s)) begin
      push_ok_s  = 1'b0;
      push_err_s = 1'b1;
      push_acc_s = {(DEPTH+1){1'b0}};
    end else begin
      push_ok_s  = 1'b1;
      push_err_s = 1'b0;
      push_acc_s = push_want_s;
    end
    we_1_s = push_ok_s && (bus.fq_i_push_cnt != 2'd0) && !bus.fq_i_flush && !fq_rst;
    we_2_s = we_1_s && (bus.fq_i_push_cnt == 2'd2);
  end

  // Pointer, occupancy and error-pulse state; reset beats flush, flush beats pop/push.
  always_ff @(posedge fq_clk) begin
    if (fq_rst) begin
      rp_r    <= {DEPTH{1'b0}};
      wp_r    <= {DEPTH{1'b0}};
      count_r <= {(DEPTH+1){1'b0}};
      err_r   <= 1'b0;
    end else if (bus.fq_i_flush) begin
      rp_r    <= {DEPTH{1'b0}};
      wp_r    <= {DEPTH{1'b0}};
      count_r <= {(DEPTH+1){1'b0}};
      err_r   <= 1'b0;
    end else begin
      rp_r    <= rp_r + eff_pop_s[DEPTH-1:0];
      wp_r    <= wp_r + push_acc_s[DEPTH-1:0];
      count_r <= count_r - eff_pop_s + push_acc_s;
      err_r   <= pop_err_s || push_err_s;
    end
  end

  fq_mem_2w1r #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (fq_clk),
    .we_1    (we_1_s),
    .waddr_1 (wp_r),
    .wdata_1 ({bus.fq_i_instr_1, bus.fq_i_pc_1}),
    .we_2    (we_2_s),
    .waddr_2 (wp_r + {{(DEPTH-1){1'b0}}, 1'b1}),
    .wdata_2 ({bus.fq_i_instr_2, bus.fq_i_pc_2}),
    .raddr_1 (rp_r),
    .rdata_1 (rdata_1_s),
    .raddr_2 (rp_r + {{(DEPTH-1){1'b0}}, 1'b1}),
    .rdata_2 (rdata_2_s)
  );

  assign bus.fq_o_count   = count_r;
  assign bus.fq_o_ready   = (count_r <= READY_MAX);
  assign bus.fq_o_err     = err_r;
  assign bus.fq_o_valid_1 = (count_r >= ONE);
  assign bus.fq_o_valid_2 = (count_r > ONE);
  assign bus.fq_o_instr_1 = bus.fq_o_valid_1 ? rdata_1_s[W-1:PC_WIDTH]   : {IWIDTH{1'b0}};
  assign bus.fq_o_pc_1    = bus.fq_o_valid_1 ? rdata_1_s[PC_WIDTH-1:0]   : {PC_WIDTH{1'b0}};
  assign bus.fq_o_instr_2 = bus.fq_o_valid_2 ? rdata_2_s[W-1:PC_WIDTH]   : {IWIDTH{1'b0}};
  assign bus.fq_o_pc_2    = bus.fq_o_valid_2 ? rdata_2_s[PC_WIDTH-1:0]   : {PC_WIDTH{1'b0}};
endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus for fetch_queue, checked against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;
  ent_t model_q[$];
  logic exp_err = 1'b0;
  logic [31:0] pc_ctr = 32'h0;

  fetch_queue_if bus ();

  fetch_queue dut (
    .fq_clk (clk),
    .fq_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_all();
    int   sz;
    ent_t e1;
    ent_t e2;
    sz = model_q.size();
    e1.instr = 32'h0; e1.pc = 32'h0;
    e2.instr = 32'h0; e2.pc = 32'h0;
    if (sz >= 1) e1 = model_q[0];
    if (sz >= 2) e2 = model_q[1];
    check("count",   32'(bus.fq_o_count), 32'(sz));
    check("ready",   32'(bus.fq_o_ready), (sz <= 6) ? 32'd1 : 32'd0);
    check("valid_1", 32'(bus.fq_o_valid_1), (sz >= 1) ? 32'd1 : 32'd0);
    check("valid_2", 32'(bus.fq_o_valid_2), (sz >= 2) ? 32'd1 : 32'd0);
    check("instr_1", bus.fq_o_instr_1, e1.instr);
    check("pc_1",    bus.fq_o_pc_1,    e1.pc);
    check("instr_2", bus.fq_o_instr_2, e2.instr);
    check("pc_2",    bus.fq_o_pc_2,    e2.pc);
    check("err",     32'(bus.fq_o_err), 32'(exp_err));
  endtask

  // Drive one cycle, advance the model, then sample after the edge.
  task automatic step(input logic r, input logic f, input logic [1:0] pu, input logic [1:0] po,
                      input logic [31:0] i1, input logic [31:0] i2);
    int   sz;
    int   want;
    int   eff;
    ent_t e;
    rst               = r;
    bus.fq_i_flush    = f;
    bus.fq_i_push_cnt = pu;
    bus.fq_i_pop_cnt  = po;
    bus.fq_i_instr_1  = i1;
    bus.fq_i_instr_2  = i2;
    bus.fq_i_pc_1     = pc_ctr;
    bus.fq_i_pc_2     = pc_ctr + 32'd4;
    @(posedge clk);
    if (r || f) begin
      model_q.delete();
      exp_err = 1'b0;
    end else begin
      sz      = model_q.size();
      want    = (po == 2'd3) ? 2 : int'(po);
      eff     = (want > sz) ? sz : want;
      exp_err = (po == 2'd3) || (want > sz);
      for (int k = 0; k < eff; k++) void'(model_q.pop_front());
      if (pu != 2'd3 && int'(pu) <= 8 - sz) begin
        if (pu >= 2'd1) begin
          e.instr = i1; e.pc = pc_ctr;
          model_q.push_back(e);
        end
        if (pu == 2'd2) begin
          e.instr = i2; e.pc = pc_ctr + 32'd4;
          model_q.push_back(e);
        end
        pc_ctr = pc_ctr + 32'(4 * int'(pu));
      end else begin
        exp_err = 1'b1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic rstep(input logic r, input logic f, input logic [1:0] pu, input logic [1:0] po);
    step(r, f, pu, po, $urandom, $urandom);
  endtask

  initial begin
    bus.fq_i_flush = 1'b0;
    bus.fq_i_push_cnt = 2'd0;
    bus.fq_i_pop_cnt = 2'd0;
    bus.fq_i_instr_1 = 32'h0;
    bus.fq_i_instr_2 = 32'h0;
    bus.fq_i_pc_1 = 32'h0;
    bus.fq_i_pc_2 = 32'h0;

    rstep(1'b1, 1'b0, 2'd0, 2'd0);
    rstep(1'b1, 1'b0, 2'd0, 2'd0);
    check("reset_count", 32'(bus.fq_o_count), 32'd0);

    // First push pair with fixed contents.
    pc_ctr = 32'h0;
    step(1'b0, 1'b0, 2'd2, 2'd0, 32'h20080001, 32'h20090002);
    check("first_instr_1", bus.fq_o_instr_1, 32'h20080001);
    check("first_pc_2",    bus.fq_o_pc_2,    32'h00000004);

    // Fill to 8, then a rejected push.
    rstep(1'b0, 1'b0, 2'd2, 2'd0);
    rstep(1'b0, 1'b0, 2'd2, 2'd0);
    check("ready_at_6", 32'(bus.fq_o_ready), 32'd1);
    rstep(1'b0, 1'b0, 2'd2, 2'd0);
    check("ready_at_8", 32'(bus.fq_o_ready), 32'd0);
    rstep(1'b0, 1'b0, 2'd1, 2'd0);
    check("full_reject_err", 32'(bus.fq_o_err), 32'd1);
    rstep(1'b0, 1'b0, 2'd0, 2'd0);

    // Full queue with push 2 + pop 2: push rejected, count 6.
    rstep(1'b0, 1'b0, 2'd2, 2'd2);
    check("full_pushpop_count", 32'(bus.fq_o_count), 32'd6);

    // Wrap-around streaming.
    for (int k = 0; k < 6; k++) begin
      rstep(1'b0, 1'b0, 2'd2, 2'd2);
      check("wrap_pc_order", bus.fq_o_pc_2 - bus.fq_o_pc_1, 32'd4);
    end

    // Drain to 1, then over-pop.
    rstep(1'b0, 1'b0, 2'd0, 2'd2);
    rstep(1'b0, 1'b0, 2'd0, 2'd2);
    rstep(1'b0, 1'b0, 2'd0, 2'd1);
    rstep(1'b0, 1'b0, 2'd0, 2'd2);
    rstep(1'b0, 1'b0, 2'd0, 2'd0);
    rstep(1'b0, 1'b0, 2'd0, 2'd3);

    // Flush at count 5 with concurrent push and pop.
    rstep(1'b0, 1'b0, 2'd2, 2'd0);
    rstep(1'b0, 1'b0, 2'd2, 2'd0);
    rstep(1'b0, 1'b0, 2'd1, 2'd0);
    rstep(1'b0, 1'b1, 2'd2, 2'd1);
    rstep(1'b0, 1'b0, 2'd1, 2'd0);

    // Reset mid-stream at count 4 with a push pending.
    rstep(1'b0, 1'b0, 2'd2, 2'd0);
    rstep(1'b0, 1'b0, 2'd1, 2'd0);
    rstep(1'b1, 1'b0, 2'd2, 2'd0);
    rstep(1'b0, 1'b0, 2'd3, 2'd0);

    // Random traffic including illegal counts, flushes and resets.
    for (int k = 0; k < 300; k++) begin
      rstep(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
